key_press_classifier: RTL

KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

---
 rtl/watch_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/key_press_classifier.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch front-panel logic: clock-derived timing
// defaults and the key classifier state encoding.
package watch_pkg;

  localparam int IN_CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_CYC_DEF = IN_CLK_HZ / 100;  // 10 ms
  localparam int LONG_CYC_DEF     = IN_CLK_HZ;        // 1 s
  localparam int REPEAT_CYC_DEF   = IN_CLK_HZ / 5;    // 200 ms

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    LONG_HELD,
    DB_RELEASE
  } key_state_e;

  // Counter width that covers the largest period; never below one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q shift as a true pipeline;
  // blocking here would collapse both flops into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_press_classifier.sv
// Debounces an active-low push-button and classifies each press as short
// (pulse on release), long (pulse at LONG_CYC) with auto-repeat while held.
module key_press_classifier
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF,
  parameter int REPEAT_CYC   = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_first,
  output logic key_long,
  output logic key_repeat,
  output logic key_held
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  logic             key_raw;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             held_d, first_d, long_d, repeat_d;

  assign key_raw = ~key_n;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_raw),
    .q     (key_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      short_q    <= 1'b0;
      key_held   <= 1'b0;
      key_first  <= 1'b0;
      key_long   <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      short_q    <= short_d;
      key_held   <= held_d;
      key_first  <= first_d;
      key_long   <= long_d;
      key_repeat <= repeat_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = short_q;
    held_d   = key_held;
    first_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end

      DB_PRESS: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!key_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Release has priority over a repeat due on the same cycle.
      LONG_HELD: begin
        if (!key_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
          short_d = 1'b0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DB_RELEASE: begin
        if (key_s) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
          first_d = short_q;
          short_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        short_d = 1'b0;
        held_d  = 1'b0;
      end
    endcase
  end

endmodule
